sd_frame_snapshot_sched: RTL

Schedules a one-frame snapshot from the SDRAM frame buffer to SD card sectors. On a debounced key press it waits for the next display frame boundary, then hands the SDRAM read FIFO to the SD writer. It issues one sector write per `wr_busy` handshake until the whole frame is stored, then returns the FIFO to the display. It sits between `key_filter`, `sd_ctrl` and the read-FIFO owner mux, and replaces the separate frame-generator and write-control logic.

---
 rtl/sd_snap_pkg.sv | 33 +++
 rtl/sd_busy_watchdog.sv | 28 ++
 rtl/sd_frame_snapshot_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sd_snap_pkg.sv
// Shared types and frame geometry for the SD snapshot schedulers.
// The default sector count is derived from the display frame size.
package sd_snap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StIssue,
    StWaitHi,
    StWaitLo,
    StNext,
    StDone,
    StErr
  } snap_state_e;

  localparam int unsigned H_PIXEL         = 1280;
  localparam int unsigned V_PIXEL         = 720;
  localparam int unsigned BYTES_PER_PIXEL = 2;
  localparam int unsigned SECTOR_BYTES    = 512;

  // Rounds up so a frame that is not a whole number of sectors is still stored completely.
  function automatic logic [15:0] frame_sectors(input int unsigned h, input int unsigned v,
                                                input int unsigned bpp,
                                                input int unsigned sect_bytes);
    int unsigned bytes;
    bytes = h * v * bpp;
    return 16'((bytes + sect_bytes - 1) / sect_bytes);
  endfunction

  localparam logic [15:0] FRAME_SECTORS_DFLT =
    frame_sectors(H_PIXEL, V_PIXEL, BYTES_PER_PIXEL, SECTOR_BYTES);

endpackage

// File: rtl/sd_busy_watchdog.sv
// Counts cycles spent waiting for the SD controller to acknowledge a sector write.
// o_timeout rises in the LIMIT-th enabled cycle after a clear.
module sd_busy_watchdog #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  logic [15:0] r_cnt;
  logic [15:0] w_limit_m1;

  assign w_limit_m1 = (LIMIT == 16'd0) ? 16'd0 : LIMIT - 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_timeout = i_en && (r_cnt >= w_limit_m1);

endmodule

// File: rtl/sd_frame_snapshot_sched.sv
// One-frame snapshot scheduler: waits for a frame boundary after a key press, then
// streams FRAME_SECTORS sector writes to sd_ctrl while owning the SDRAM read FIFO.
module sd_frame_snapshot_sched
  import sd_snap_pkg::*;
#(
  parameter logic [31:0] SECTOR_BASE   = 32'd1000,
  parameter logic [15:0] FRAME_SECTORS = FRAME_SECTORS_DFLT,
  parameter logic [15:0] BUSY_TIMEOUT  = 16'd50000
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_key_flag,
  input  logic        i_frame_start,
  input  logic        i_sd_init_end,
  input  logic        i_wr_busy,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic        o_frame,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_sect_cnt
);

  snap_state_e r_state;
  snap_state_e w_state_d;

  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic        r_frame;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_sect_cnt;

  logic w_wd_clr;
  logic w_wd_en;
  logic w_timeout;
  logic w_accept;
  logic w_launch;
  logic w_sect_done;
  logic w_addr_step;

  assign w_wd_clr = (r_state == StIssue);
  assign w_wd_en  = (r_state == StWaitHi);

  sd_busy_watchdog #(
    .LIMIT (BUSY_TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_sys_clk),
    .i_rst     (i_sys_rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_key_flag && i_sd_init_end) begin
          w_state_d = StArm;
        end
      end
      StArm: begin
        if (i_frame_start) begin
          w_state_d = StIssue;
        end
      end
      // A busy already high alongside wr_en counts as the acknowledge.
      StIssue: begin
        w_state_d = i_wr_busy ? StWaitLo : StWaitHi;
      end
      StWaitHi: begin
        if (i_wr_busy) begin
          w_state_d = StWaitLo;
        end else if (w_timeout) begin
          w_state_d = StErr;
        end
      end
      StWaitLo: begin
        if (!i_wr_busy) begin
          w_state_d = StNext;
        end
      end
      StNext: begin
        w_state_d = (r_sect_cnt == FRAME_SECTORS) ? StDone : StIssue;
      end
      StDone:  w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_accept    = (r_state == StIdle)   && (w_state_d == StArm);
  assign w_launch    = (r_state == StArm)    && (w_state_d == StIssue);
  assign w_sect_done = (r_state == StWaitLo) && (w_state_d == StNext);
  assign w_addr_step = (r_state == StNext)   && (w_state_d == StIssue);

  // Outputs are computed from the next state so every output is a flop.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state    <= StIdle;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= SECTOR_BASE;
      r_frame    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sect_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      r_wr_en <= (w_state_d == StIssue);
      r_busy  <= (w_state_d != StIdle);
      r_done  <= (w_state_d == StDone);
      if (w_accept) begin
        r_err      <= 1'b0;
        r_sect_cnt <= '0;
        r_wr_addr  <= SECTOR_BASE;
      end
      if (w_launch) begin
        r_frame <= 1'b1;
      end
      if ((w_state_d == StDone) || (w_state_d == StErr)) begin
        r_frame <= 1'b0;
      end
      if (w_state_d == StErr) begin
        r_err <= 1'b1;
      end
      if (w_sect_done) begin
        r_sect_cnt <= r_sect_cnt + 16'd1;
      end
      if (w_addr_step) begin
        r_wr_addr <= r_wr_addr + 32'd1;
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_frame    = r_frame;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_sect_cnt = r_sect_cnt;

endmodule
